decoder_scan_seq: RTL and testbench
===================================

Name: decoder_scan_seq

Overview:
Parametrised, registered N-to-2^N one-hot decoder with output enable. It is the sequential successor of the team's gate-level 2-to-4 and 3-to-8 decoders. It adds two modes: direct load of a decoded address, and an auto-scan mode that walks the active output line with a programmable dwell time. It is used as a row/column strobe generator and as a device-select sequencer.

Parameters:
N, 3, address width; output width is 2^N.
DWELL, 1, clock cycles each output stays active in scan mode (legal range 1..255).

Ports:
CLK  input  1  system clock, rising-edge active.
RST  input  1  asynchronous, active-high reset.
A  input  N  address to decode or load.
LD  input  1  load strobe; captures A into the index on a rising CLK edge.
OE  input  1  output enable; 0 forces Y to zero and freezes the sequencer.
MODE  input  1  0 = direct decode, 1 = auto-scan.
Y  output  2^N  registered one-hot output.
IDX  output  N  current index register.
WRAP  output  1  one-cycle pulse on a scan wrap.

Behaviour:
- One clock (CLK). RST is asynchronous and active-high.
- Reset values: IDX=0, Y=0, WRAP=0, dwell counter=0, FSM=IDLE.
- Internal registers: index idx[N-1:0] (driven out on IDX), dwell counter dcnt[7:0], FSM state.
- Y is registered: Y = onehot(idx) when the FSM is in DIRECT or SCAN, otherwise 0. Y updates in the same edge as idx, so latency from LD/A to Y is 1 cycle.
- FSM states: IDLE, DIRECT, SCAN.
  - Any state -> IDLE when OE=0 at the edge.
  - IDLE -> DIRECT when OE=1 and MODE=0.
  - IDLE -> SCAN when OE=1 and MODE=1.
  - DIRECT <-> SCAN follows MODE while OE=1.
- IDLE:
  - Y=0, WRAP=0.
  - idx and dcnt hold their values.
  - LD is still honoured: idx<=A.
- DIRECT:
  - LD=1 -> idx<=A.
  - Otherwise idx holds. dcnt is held at 0. WRAP=0.
- SCAN:
  - If dcnt==DWELL-1: dcnt<=0 and idx<=idx+1 (modulo 2^N).
  - Otherwise dcnt<=dcnt+1.
- Wrap: when idx advances from 2^N-1 to 0, WRAP=1 for exactly that cycle, coincident with Y=onehot(0). WRAP is 0 in all other cycles.
- Priority: LD beats advance. LD=1 in SCAN gives idx<=A and dcnt<=0, with no WRAP even if A=0.
- Any mode change (DIRECT<->SCAN or entry from IDLE) clears dcnt to 0. The first scan step therefore dwells the full DWELL cycles.
- DWELL=1: idx advances every cycle in SCAN.
- RST mid-scan: all registers return to their reset values at once, without waiting for CLK. Operation resumes from idx=0 after RST is released.
- Y is never multi-hot. It is all-zero only in IDLE or during reset.

Optional Feature:
Macro DEC_BIDIR_EN.
- Defined: adds port DIR (input, 1 bit).
  - DIR=0: scan counts up (as above).
  - DIR=1: scan counts down, modulo 2^N. WRAP pulses on the step from 0 to 2^N-1.
  - DIR changes take effect at the next advance and do not clear dcnt.
- Undefined: no DIR port; scan is up-only.

Test Plan:
1. Reset: N=3, assert RST asynchronously mid-cycle -> Y=8'h00, IDX=0, WRAP=0 immediately.
2. Direct decode: OE=1, MODE=0; LD=1, A=3'd5 -> next cycle Y=8'h20, IDX=5. Then OE=0 -> next cycle Y=8'h00, IDX stays 5.
3. Scan with dwell: DWELL=2, OE=1, MODE=1, starting at idx=6 -> Y shows 8'h40 for 2 cycles, then 8'h80 for 2 cycles, then 8'h01 with WRAP=1 for the first cycle only.
4. Load during scan: scan running at idx=2, mid-dwell; LD=1, A=0 -> Y=8'h01 next cycle, WRAP=0, full 2-cycle dwell follows.
5. Freeze: during scan, OE=0 for 3 cycles then OE=1 -> Y=0 while frozen; scan resumes at the same idx with dcnt=0.
6. DEC_BIDIR_EN: DIR=1, DWELL=1, idx=1 -> Y sequence 8'h02, 8'h01, 8'h80 (WRAP=1), 8'h40.

Source files
------------

// File: rtl/decoder_scan_seq.sv
`default_nettype none
// ============================================================================
// decoder_scan_seq : registered N-to-2^N one-hot decoder with direct-load and
//                    auto-scan modes, output enable and scan-wrap pulse.
//                    Optional macro DEC_BIDIR_EN adds dir_i (1 = scan down).
// Revision: 1.0
// ============================================================================
module decoder_scan_seq #(
  parameter int N     = 3,
  parameter int DWELL = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N-1:0]      a_i,
  input  logic              ld_i,
  input  logic              oe_i,
  input  logic              mode_i,
`ifdef DEC_BIDIR_EN
  input  logic              dir_i,
`endif
  output logic [2**N-1:0]   y_o,
  output logic [N-1:0]      idx_o,
  output logic              wrap_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic [7:0]   DWELL_LAST = 8'(DWELL - 1);
  localparam logic [N-1:0] IDX_MAX    = {N{1'b1}};
  localparam logic [N-1:0] IDX_ONE    = {{(N-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [N-1:0]      idx_q, idx_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic              wrap_q, wrap_d;
  logic [2**N-1:0]   y_q, y_d;
  logic              step_down;

`ifdef DEC_BIDIR_EN
  assign step_down = dir_i;
`else
  assign step_down = 1'b0;
`endif

  always_comb begin
    state_d = ST_IDLE;
    if (oe_i) begin
      state_d = mode_i ? ST_SCAN : ST_DIRECT;
    end
    idx_d  = idx_q;
    dcnt_d = dcnt_q;
    wrap_d = 1'b0;

    if (state_d == ST_IDLE) begin
      // Frozen: counter holds, but a load still lands in the index.
      if (ld_i) begin
        idx_d = a_i;
      end
    end else if ((state_d != state_q) || (state_d == ST_DIRECT) || ld_i) begin
      // Mode entry, direct decode, or load: restart the dwell from zero.
      dcnt_d = 8'd0;
      if (ld_i) begin
        idx_d = a_i;
      end
    end else if (dcnt_q == DWELL_LAST) begin
      dcnt_d = 8'd0;
      if (step_down) begin
        idx_d  = idx_q - IDX_ONE;
        wrap_d = (idx_q == '0);
      end else begin
        idx_d  = idx_q + IDX_ONE;
        wrap_d = (idx_q == IDX_MAX);
      end
    end else begin
      dcnt_d = dcnt_q + 8'd1;
    end

    y_d = '0;
    if (state_d != ST_IDLE) begin
      y_d[idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dcnt_q  <= 8'd0;
      wrap_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign y_o    = y_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_seq.sv
`default_nettype none
// ============================================================================
// tb_decoder_scan_seq : directed plus random checks of decoder_scan_seq
//                       (N=3, DWELL=2) against an anchor/elapsed-time model.
// Revision: 1.0
// ============================================================================
module tb_decoder_scan_seq;

  localparam int N     = 3;
  localparam int SIZE  = 8;
  localparam int DWELL = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    a;
  logic            ld, oe, mode, dir;
  logic [SIZE-1:0] y;
  logic [N-1:0]    idx;
  logic            wrap;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: scan position is base index plus elapsed scan cycles / DWELL.
  int m_st;
  int m_cur, m_base, m_t, m_dir;
  bit m_wrap;

  always #5 clk = ~clk;

  decoder_scan_seq #(.N(N), .DWELL(DWELL)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .a_i    (a),
    .ld_i   (ld),
    .oe_i   (oe),
    .mode_i (mode),
`ifdef DEC_BIDIR_EN
    .dir_i  (dir),
`endif
    .y_o    (y),
    .idx_o  (idx),
    .wrap_o (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cur = 0; m_base = 0; m_t = 0; m_wrap = 0; m_dir = 0;
  endtask

  task automatic model_edge();
    int nst;
    int steps;
    nst    = !oe ? 0 : (mode ? 2 : 1);
    m_wrap = 0;
    if (nst == 2 && m_st == 2 && !ld) begin
      m_t++;
      if (m_t % DWELL == 0) begin
        steps  = m_t / DWELL;
        m_cur  = ((m_base + (m_dir != 0 ? -steps : steps)) % SIZE + SIZE) % SIZE;
        m_wrap = (m_dir != 0) ? (m_cur == SIZE - 1) : (m_cur == 0);
      end
    end else begin
      if (ld) m_cur = int'(a);
      m_base = m_cur;
      m_t    = 0;
      m_dir  = int'(dir);
    end
    m_st = nst;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ey;
    ey = (m_st != 0) ? (32'd1 << m_cur) : 32'd0;
    chk({tag, "_y"},    32'(y),    ey);
    chk({tag, "_idx"},  32'(idx),  32'(m_cur));
    chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; a = '0; ld = 1'b0; oe = 1'b0; mode = 1'b0; dir = 1'b0;
    model_reset();
    #2;
    chk("por_y", 32'(y), 32'd0);
    chk("por_idx", 32'(idx), 32'd0);
    chk("por_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Direct decode then disable.
    oe = 1'b1; mode = 1'b0; ld = 1'b1; a = 3'd5;
    step("dir_ld");
    chk("dir_y20", 32'(y), 32'h20);
    chk("dir_idx5", 32'(idx), 32'd5);
    ld = 1'b0; oe = 1'b0;
    step("dir_off");
    chk("off_y0", 32'(y), 32'h00);
    chk("off_idx5", 32'(idx), 32'd5);

    // Scan from 6 with DWELL=2 across the wrap.
    oe = 1'b1; ld = 1'b1; a = 3'd6;
    step("scan_pre");
    ld = 1'b0; mode = 1'b1;
    step("scan_e");  chk("scan_e_y", 32'(y), 32'h40);
    step("scan_1");  chk("scan_1_y", 32'(y), 32'h40);
    step("scan_2");  chk("scan_2_y", 32'(y), 32'h80);
    step("scan_3");  chk("scan_3_y", 32'(y), 32'h80);
    step("scan_4");  chk("scan_4_y", 32'(y), 32'h01); chk("scan_4_w", 32'(wrap), 32'd1);
    step("scan_5");  chk("scan_5_w", 32'(wrap), 32'd0);
    step("scan_6");  chk("scan_6_y", 32'(y), 32'h02);
    step("scan_7");

    // Load A=0 mid-dwell: no wrap, full dwell after.
    ld = 1'b1; a = 3'd0;
    step("lds");     chk("lds_y", 32'(y), 32'h01); chk("lds_w", 32'(wrap), 32'd0);
    ld = 1'b0;
    step("lds_1");   chk("lds_1_y", 32'(y), 32'h01);
    step("lds_2");   chk("lds_2_y", 32'(y), 32'h02);

    // Freeze for three cycles and resume with a fresh dwell.
    oe = 1'b0;
    for (int i = 0; i < 3; i++) step("frz");
    chk("frz_y", 32'(y), 32'h00);
    oe = 1'b1;
    step("res_e");   chk("res_e_y", 32'(y), 32'h02);
    step("res_1");   chk("res_1_y", 32'(y), 32'h02);
    step("res_2");   chk("res_2_y", 32'(y), 32'h04);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("ares_y", 32'(y), 32'd0);
    chk("ares_idx", 32'(idx), 32'd0);
    chk("ares_wrap", 32'(wrap), 32'd0);
    #1 rst = 1'b0;
    step("post_rst"); chk("post_rst_y", 32'(y), 32'h01);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      oe = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 5) == 0);
      a  = N'($urandom_range(0, SIZE - 1));
      if ($urandom_range(0, 3) == 0) mode = ~mode;
`ifdef DEC_BIDIR_EN
      if (ld || !oe) dir = 1'($urandom_range(0, 1));
`endif
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
